// File: rtl/mcu_spi_arbiter.sv
// MCU SPI bus arbiter: shares one MCU SPI port between the RTC engine and the
// host SPI engine. Ownership is granted per transaction, ties alternate, a
// guard gap keeps nMCUSel high between owners, and illegal chip-select
// activity from a non-owner raises a sticky conflict flag.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | bus free, requests sampled, tie goes to the non-last owner
// RTC_OWN  | RTC engine owns the bus, its signals are routed to the MCU
// HOST_OWN | host engine owns the bus, its signals are routed to the MCU
// GUARD    | bus idle for GUARD_CYCLES cycles, requests ignored
module mcu_spi_arbiter #(
  parameter int GUARD_CYCLES = 2
) (
  input  logic SClk,
  input  logic Reset,
  input  logic RTCReq,
  output logic RTCGrant,
  input  logic RTCnSel,
  input  logic RTCDo,
  input  logic RTCClkRunning,
  input  logic RTCClkStretch,
  output logic RTCDi,
  input  logic HostReq,
  input  logic HostnSel,
  input  logic HostDo,
  input  logic HostClkRunning,
  output logic HostGrant,
  output logic HostDi,
  input  logic SPIMiso,
  output logic SPIMosi,
  output logic nMCUSel,
  output logic SPIClkEn,
  input  logic ErrClear,
  output logic ConflictErr
);

  localparam int CW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CW-1:0] GUARD_LOAD = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, RTC_OWN, HOST_OWN, GUARD} state_t;

  state_t          state;
  logic            last_host;
  logic [CW-1:0]   guard_cnt;
  logic            conflict;

  // Ownership FSM with registered grants; grants never see Req combinationally.
  always_ff @(posedge SClk) begin
    if (Reset) begin
      state     <= IDLE;
      last_host <= 1'b1;
      guard_cnt <= '0;
      RTCGrant  <= 1'b0;
      HostGrant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (RTCReq && (!HostReq || last_host)) begin
            state     <= RTC_OWN;
            last_host <= 1'b0;
            RTCGrant  <= 1'b1;
          end else if (HostReq) begin
            state     <= HOST_OWN;
            last_host <= 1'b1;
            HostGrant <= 1'b1;
          end
        end
        RTC_OWN: begin
          // Release only once the owner has also deasserted its chip select.
          if (!RTCReq && RTCnSel) begin
            RTCGrant <= 1'b0;
            if (GUARD_CYCLES > 0) begin
              state     <= GUARD;
              guard_cnt <= GUARD_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        HOST_OWN: begin
          if (!HostReq && HostnSel) begin
            HostGrant <= 1'b0;
            if (GUARD_CYCLES > 0) begin
              state     <= GUARD;
              guard_cnt <= GUARD_LOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        GUARD: begin
          if (guard_cnt == '0) state <= IDLE;
          else                 guard_cnt <= guard_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Any chip select driven low by a master that does not own the bus.
  always_comb begin
    conflict = 1'b0;
    case (state)
      RTC_OWN:  conflict = !HostnSel;
      HOST_OWN: conflict = !RTCnSel;
      default:  conflict = !RTCnSel || !HostnSel;
    endcase
  end

  // Sticky conflict flag; a fresh conflict takes priority over a clear.
  always_ff @(posedge SClk) begin
    if (Reset)         ConflictErr <= 1'b0;
    else if (conflict) ConflictErr <= 1'b1;
    else if (ErrClear) ConflictErr <= 1'b0;
  end

  // Bus routing from the registered owner state; unowned bus is parked high.
  always_comb begin
    nMCUSel  = 1'b1;
    SPIMosi  = 1'b1;
    SPIClkEn = 1'b0;
    RTCDi    = 1'b1;
    HostDi   = 1'b1;
    case (state)
      RTC_OWN: begin
        nMCUSel  = RTCnSel;
        SPIMosi  = RTCDo;
        SPIClkEn = RTCClkRunning & ~RTCClkStretch;
        RTCDi    = SPIMiso;
      end
      HOST_OWN: begin
        nMCUSel  = HostnSel;
        SPIMosi  = HostDo;
        SPIClkEn = HostClkRunning;
        HostDi   = SPIMiso;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mcu_spi_arbiter.sv
// Directed bench for mcu_spi_arbiter: default-guard instance plus a
// zero-guard instance for back-to-back handover.
module tb_mcu_spi_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // default instance (GUARD_CYCLES = 2)
  logic rst, rtc_req, rtc_nsel, rtc_do, rtc_run, rtc_str;
  logic host_req, host_nsel, host_do, host_run, miso, err_clr;
  logic rtc_grant, rtc_di, host_grant, host_di, mosi, nsel, clk_en, err;

  // zero-guard instance
  logic rst_b, rtc_req_b, host_req_b, host_nsel_b;
  logic rtc_grant_b, rtc_di_b, host_grant_b, host_di_b, mosi_b, nsel_b, clk_en_b, err_b;

  mcu_spi_arbiter #(.GUARD_CYCLES(2)) dut (
    .SClk(clk), .Reset(rst),
    .RTCReq(rtc_req), .RTCGrant(rtc_grant), .RTCnSel(rtc_nsel), .RTCDo(rtc_do),
    .RTCClkRunning(rtc_run), .RTCClkStretch(rtc_str), .RTCDi(rtc_di),
    .HostReq(host_req), .HostnSel(host_nsel), .HostDo(host_do),
    .HostClkRunning(host_run), .HostGrant(host_grant), .HostDi(host_di),
    .SPIMiso(miso), .SPIMosi(mosi), .nMCUSel(nsel), .SPIClkEn(clk_en),
    .ErrClear(err_clr), .ConflictErr(err)
  );

  mcu_spi_arbiter #(.GUARD_CYCLES(0)) dut_b (
    .SClk(clk), .Reset(rst_b),
    .RTCReq(rtc_req_b), .RTCGrant(rtc_grant_b), .RTCnSel(1'b1), .RTCDo(1'b1),
    .RTCClkRunning(1'b0), .RTCClkStretch(1'b0), .RTCDi(rtc_di_b),
    .HostReq(host_req_b), .HostnSel(host_nsel_b), .HostDo(1'b1),
    .HostClkRunning(1'b0), .HostGrant(host_grant_b), .HostDi(host_di_b),
    .SPIMiso(1'b0), .SPIMosi(mosi_b), .nMCUSel(nsel_b), .SPIClkEn(clk_en_b),
    .ErrClear(1'b0), .ConflictErr(err_b)
  );

  // one clock: inputs driven now are sampled at the next edge, checks follow it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; miso = 1'b0;
    step();
    rst = 1'b0;
    n_checks++; if (rtc_grant !== 1'b0)  begin n_fail++; $display("FAIL reset_rtc_grant got %b exp 0", rtc_grant); end
    n_checks++; if (host_grant !== 1'b0) begin n_fail++; $display("FAIL reset_host_grant got %b exp 0", host_grant); end
    n_checks++; if (nsel !== 1'b1)       begin n_fail++; $display("FAIL reset_nsel got %b exp 1", nsel); end
    n_checks++; if (mosi !== 1'b1)       begin n_fail++; $display("FAIL reset_mosi got %b exp 1", mosi); end
    n_checks++; if (clk_en !== 1'b0)     begin n_fail++; $display("FAIL reset_clk_en got %b exp 0", clk_en); end
    n_checks++; if (rtc_di !== 1'b1)     begin n_fail++; $display("FAIL reset_rtc_di got %b exp 1", rtc_di); end
    n_checks++; if (host_di !== 1'b1)    begin n_fail++; $display("FAIL reset_host_di got %b exp 1", host_di); end
    n_checks++; if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_tie();
    rtc_req = 1'b1; host_req = 1'b1;
    step();
    n_checks++; if (rtc_grant !== 1'b1)  begin n_fail++; $display("FAIL tie_rtc_grant got %b exp 1", rtc_grant); end
    n_checks++; if (host_grant !== 1'b0) begin n_fail++; $display("FAIL tie_host_grant got %b exp 0", host_grant); end
    rtc_req = 1'b0;
    step();
    n_checks++; if (rtc_grant !== 1'b0)  begin n_fail++; $display("FAIL tie_release_rtc got %b exp 0", rtc_grant); end
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (host_grant !== 1'b0) begin n_fail++; $display("FAIL tie_guard_host_grant cyc %0d got %b exp 0", i, host_grant); end
      step();
    end
    n_checks++; if (host_grant !== 1'b0) begin n_fail++; $display("FAIL tie_idle_host_grant got %b exp 0", host_grant); end
    step();
    n_checks++; if (host_grant !== 1'b1) begin n_fail++; $display("FAIL tie_host_after_guard got %b exp 1", host_grant); end
    host_req = 1'b0;
    repeat (3) step();
    n_checks++; if (host_grant !== 1'b0) begin n_fail++; $display("FAIL tie_host_released got %b exp 0", host_grant); end
  endtask

  task automatic test_rtc_clock();
    rtc_req = 1'b1;
    step();
    n_checks++; if (rtc_grant !== 1'b1) begin n_fail++; $display("FAIL clk_rtc_grant got %b exp 1", rtc_grant); end
    rtc_nsel = 1'b0; rtc_run = 1'b1; rtc_str = 1'b1; rtc_do = 1'b0; miso = 1'b0;
    #1;
    n_checks++; if (clk_en !== 1'b0)  begin n_fail++; $display("FAIL clk_stretch1 got %b exp 0", clk_en); end
    n_checks++; if (nsel !== 1'b0)    begin n_fail++; $display("FAIL clk_nsel got %b exp 0", nsel); end
    n_checks++; if (mosi !== 1'b0)    begin n_fail++; $display("FAIL clk_mosi0 got %b exp 0", mosi); end
    n_checks++; if (rtc_di !== 1'b0)  begin n_fail++; $display("FAIL clk_rtc_di0 got %b exp 0", rtc_di); end
    n_checks++; if (host_di !== 1'b1) begin n_fail++; $display("FAIL clk_host_di got %b exp 1", host_di); end
    step();
    rtc_str = 1'b0; rtc_do = 1'b1; miso = 1'b1;
    #1;
    n_checks++; if (clk_en !== 1'b1)  begin n_fail++; $display("FAIL clk_run got %b exp 1", clk_en); end
    n_checks++; if (mosi !== 1'b1)    begin n_fail++; $display("FAIL clk_mosi1 got %b exp 1", mosi); end
    n_checks++; if (rtc_di !== 1'b1)  begin n_fail++; $display("FAIL clk_rtc_di1 got %b exp 1", rtc_di); end
    step();
    rtc_str = 1'b1; rtc_do = 1'b0; miso = 1'b0;
    #1;
    n_checks++; if (clk_en !== 1'b0)  begin n_fail++; $display("FAIL clk_stretch2 got %b exp 0", clk_en); end
    n_checks++; if (mosi !== 1'b0)    begin n_fail++; $display("FAIL clk_mosi2 got %b exp 0", mosi); end
    n_checks++; if (host_di !== 1'b1) begin n_fail++; $display("FAIL clk_host_di2 got %b exp 1", host_di); end
    rtc_nsel = 1'b1; rtc_req = 1'b0; rtc_run = 1'b0; rtc_str = 1'b0; rtc_do = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_no_revoke();
    host_req = 1'b1;
    step();
    n_checks++; if (host_grant !== 1'b1) begin n_fail++; $display("FAIL hold_grant got %b exp 1", host_grant); end
    host_req = 1'b0; host_nsel = 1'b0; host_run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (host_grant !== 1'b1) begin n_fail++; $display("FAIL hold_cyc%0d got %b exp 1", i, host_grant); end
      n_checks++; if (clk_en !== 1'b1)     begin n_fail++; $display("FAIL hold_clk_en%0d got %b exp 1", i, clk_en); end
    end
    host_nsel = 1'b1; host_run = 1'b0; rtc_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (host_grant !== 1'b0 || rtc_grant !== 1'b0) begin n_fail++; $display("FAIL gap%0d grants got %b%b exp 00", i, host_grant, rtc_grant); end
      n_checks++; if (nsel !== 1'b1) begin n_fail++; $display("FAIL gap%0d nsel got %b exp 1", i, nsel); end
    end
    step();
    n_checks++; if (rtc_grant !== 1'b1) begin n_fail++; $display("FAIL gap_next_grant got %b exp 1", rtc_grant); end
    rtc_req = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_conflict();
    host_req = 1'b1;
    step();
    host_nsel = 1'b0; rtc_nsel = 1'b0;
    #1;
    n_checks++; if (nsel !== 1'b0) begin n_fail++; $display("FAIL cfl_nsel got %b exp 0", nsel); end
    step();
    rtc_nsel = 1'b1;
    n_checks++; if (err !== 1'b1)  begin n_fail++; $display("FAIL cfl_set got %b exp 1", err); end
    n_checks++; if (nsel !== 1'b0) begin n_fail++; $display("FAIL cfl_route got %b exp 0", nsel); end
    err_clr = 1'b1;
    step();
    n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL cfl_clear got %b exp 0", err); end
    rtc_nsel = 1'b0;
    step();
    n_checks++; if (err !== 1'b1)  begin n_fail++; $display("FAIL cfl_wins_clear got %b exp 1", err); end
    rtc_nsel = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL cfl_clear2 got %b exp 0", err); end
    host_nsel = 1'b1; host_req = 1'b0;
    repeat (3) step();
    host_nsel = 1'b0;
    step();
    host_nsel = 1'b1;
    n_checks++; if (err !== 1'b1)  begin n_fail++; $display("FAIL cfl_idle got %b exp 1", err); end
    n_checks++; if (nsel !== 1'b1) begin n_fail++; $display("FAIL cfl_idle_nsel got %b exp 1", nsel); end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL cfl_idle_clear got %b exp 0", err); end
  endtask

  task automatic test_reset_mid();
    rtc_req = 1'b1;
    step();
    rtc_nsel = 1'b0; rtc_run = 1'b1; host_nsel = 1'b0;
    #1;
    n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL mid_clk_en got %b exp 1", clk_en); end
    step();
    n_checks++; if (err !== 1'b1)    begin n_fail++; $display("FAIL mid_err got %b exp 1", err); end
    rst = 1'b1;
    step();
    n_checks++; if (nsel !== 1'b1)      begin n_fail++; $display("FAIL mid_nsel got %b exp 1", nsel); end
    n_checks++; if (clk_en !== 1'b0)    begin n_fail++; $display("FAIL mid_clk_en_off got %b exp 0", clk_en); end
    n_checks++; if (rtc_grant !== 1'b0) begin n_fail++; $display("FAIL mid_grant got %b exp 0", rtc_grant); end
    n_checks++; if (err !== 1'b0)       begin n_fail++; $display("FAIL mid_err_clr got %b exp 0", err); end
    rst = 1'b0; rtc_req = 1'b0; rtc_nsel = 1'b1; rtc_run = 1'b0; host_nsel = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0; host_req_b = 1'b1;
    step();
    n_checks++; if (host_grant_b !== 1'b1) begin n_fail++; $display("FAIL b2b_host_grant got %b exp 1", host_grant_b); end
    host_req_b = 1'b0;
    step();
    rtc_req_b = 1'b1;
    n_checks++; if (host_grant_b !== 1'b0 || rtc_grant_b !== 1'b0) begin n_fail++; $display("FAIL b2b_idle grants got %b%b exp 00", host_grant_b, rtc_grant_b); end
    n_checks++; if (nsel_b !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_nsel got %b exp 1", nsel_b); end
    step();
    n_checks++; if (rtc_grant_b !== 1'b1) begin n_fail++; $display("FAIL b2b_rtc_grant got %b exp 1", rtc_grant_b); end
    rtc_req_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rtc_req = 1'b0; rtc_nsel = 1'b1; rtc_do = 1'b1; rtc_run = 1'b0; rtc_str = 1'b0;
    host_req = 1'b0; host_nsel = 1'b1; host_do = 1'b1; host_run = 1'b0; miso = 1'b0; err_clr = 1'b0;
    rst_b = 1'b1; rtc_req_b = 1'b0; host_req_b = 1'b0; host_nsel_b = 1'b1;
    #1;
    test_reset();
    test_tie();
    test_rtc_clock();
    test_no_revoke();
    test_conflict();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
